// File: rtl/assoc_cache_controller_if.sv
// Requester and backing-store signal bundle for the two-way cache controller.
// The controller takes the slave view; the environment driving requests and
// modelling the SRAM takes the master view.
interface assoc_cache_controller_if #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 2
);
  // Requester side
  logic                         mem_read_en;
  logic                         mem_write_en;
  logic [ADDR_W-1:0]            address;
  logic [DATA_W-1:0]            write_data;
  logic [DATA_W-1:0]            read_data;
  logic                         ready;
  // Backing-store side
  logic                         sram_read_en;
  logic                         sram_write_en;
  logic [ADDR_W-1:0]            sram_address;
  logic [DATA_W-1:0]            sram_write_data;
  logic [LINE_WORDS*DATA_W-1:0] sram_read_data;
  logic                         sram_ready;

  modport slave (
    input  mem_read_en, mem_write_en, address, write_data,
    input  sram_read_data, sram_ready,
    output read_data, ready,
    output sram_read_en, sram_write_en, sram_address, sram_write_data
  );

  modport master (
    output mem_read_en, mem_write_en, address, write_data,
    output sram_read_data, sram_ready,
    input  read_data, ready,
    input  sram_read_en, sram_write_en, sram_address, sram_write_data
  );
endinterface

// File: rtl/assoc_cache_controller.sv
// Two-way set-associative, write-through, no-write-allocate cache controller.
// Loads that hit complete in the same cycle; misses fetch a whole line from
// the backing store. Stores always go to the backing store and update the
// cached copy only when the line is already present.
module assoc_cache_controller #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 2,
  parameter int INDEX_W    = 6,
  parameter int BASE_ADDR  = 1024
) (
  input logic                    clk,
  input logic                    rst,
  assoc_cache_controller_if.slave bus
);
  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int TAG_W = ADDR_W - 2 - OFF_W - INDEX_W;
  localparam int SETS  = 1 << INDEX_W;

  typedef enum logic [1:0] {IDLE, MISS, WRITE} state_t;

  state_t state_q, state_d;

  // Line storage; only the valid and LRU bits need a defined reset value
  logic [DATA_W-1:0]      data_q [2][SETS][LINE_WORDS];
  logic [TAG_W-1:0]       tag_q  [2][SETS];
  logic [1:0][SETS-1:0]   valid_q, valid_d;
  logic [SETS-1:0]        lru_q, lru_d;

  logic [ADDR_W-1:0]      real_addr;
  logic [OFF_W-1:0]       word;
  logic [INDEX_W-1:0]     idx;
  logic [TAG_W-1:0]       tag;
  logic                   hit0, hit1, hit, hit_way;
  logic                   fill_en, fill_way, wr_en;

  // Address decomposition and hit detection; the byte offset is masked off
  // and the whole of real_addr is consumed through shifts
  always_comb begin
    real_addr = (bus.address & ~ADDR_W'(3)) - ADDR_W'(BASE_ADDR);
    word      = OFF_W'(real_addr >> 2);
    idx       = INDEX_W'(real_addr >> (2 + OFF_W));
    tag       = TAG_W'(real_addr >> (2 + OFF_W + INDEX_W));
    hit0      = !rst && valid_q[0][idx] && (tag_q[0][idx] == tag);
    hit1      = !rst && valid_q[1][idx] && (tag_q[1][idx] == tag);
    hit       = hit0 || hit1;
    hit_way   = !hit0;
  end

  // Next-state, bookkeeping updates and all outputs
  always_comb begin
    state_d             = state_q;
    valid_d             = valid_q;
    lru_d               = lru_q;
    fill_en             = 1'b0;
    fill_way            = 1'b0;
    wr_en               = 1'b0;
    bus.ready           = 1'b0;
    bus.read_data       = '0;
    bus.sram_read_en    = 1'b0;
    bus.sram_write_en   = 1'b0;
    bus.sram_address    = '0;
    bus.sram_write_data = '0;
    unique case (state_q)
      IDLE: begin
        if (bus.mem_read_en) begin
          if (hit) begin
            bus.ready     = 1'b1;
            bus.read_data = data_q[hit_way][idx][word];
            lru_d[idx]    = ~hit_way;
          end else begin
            state_d = MISS;
          end
        end else if (bus.mem_write_en) begin
          state_d = WRITE;
          if (hit) begin
            wr_en      = 1'b1;
            lru_d[idx] = ~hit_way;
          end
        end else begin
          bus.ready = 1'b1;
        end
      end
      MISS: begin
        bus.sram_read_en = 1'b1;
        bus.sram_address = bus.address;
        if (bus.sram_ready) begin
          fill_en  = 1'b1;
          // Prefer an empty way before evicting the least recently used one
          if (!valid_q[0][idx])      fill_way = 1'b0;
          else if (!valid_q[1][idx]) fill_way = 1'b1;
          else                       fill_way = lru_q[idx];
          valid_d[fill_way][idx] = 1'b1;
          lru_d[idx]             = ~fill_way;
          bus.read_data = bus.sram_read_data[int'(word)*DATA_W +: DATA_W];
          bus.ready     = 1'b1;
          state_d       = IDLE;
        end
      end
      WRITE: begin
        bus.sram_write_en   = 1'b1;
        bus.sram_address    = bus.address;
        bus.sram_write_data = bus.write_data;
        if (bus.sram_ready) begin
          bus.ready = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state: FSM, valid and LRU bits, cleared immediately by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      valid_q <= '0;
      lru_q   <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      lru_q   <= lru_d;
    end
  end

  // Tag and data arrays: line fill on miss completion, word update on store hit
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[fill_way][idx] <= tag;
      for (int w = 0; w < LINE_WORDS; w++) begin
        data_q[fill_way][idx][w] <= bus.sram_read_data[w*DATA_W +: DATA_W];
      end
    end else if (wr_en) begin
      data_q[hit_way][idx][word] <= bus.write_data;
    end
  end
endmodule

// File: tb/tb_assoc_cache_controller.sv
// Directed bench for the two-way cache controller: line fills, same-cycle
// hits, LRU replacement, write-through behaviour and reset abort.
module tb_assoc_cache_controller;
  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int LINE_WORDS = 2;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  assoc_cache_controller_if #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINE_WORDS(LINE_WORDS)
  ) bus ();

  assoc_cache_controller #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINE_WORDS(LINE_WORDS),
    .INDEX_W(6), .BASE_ADDR(1024)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata);
    bus.mem_read_en  = rd;
    bus.mem_write_en = wr;
    bus.address      = addr;
    bus.write_data   = wdata;
  endtask

  task automatic read_hit(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    set_req(1'b1, 1'b0, addr, 32'h0);
    #1;
    chk({tag, "_ready"}, bus.ready, 1'b1);
    chk({tag, "_data"}, bus.read_data, exp);
    chk({tag, "_no_sram_rd"}, bus.sram_read_en, 1'b0);
    tick();
    set_req(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic read_miss(input string tag, input logic [31:0] addr,
                           input logic [63:0] line, input logic [31:0] exp);
    set_req(1'b1, 1'b0, addr, 32'h0);
    #1;
    chk({tag, "_idle_ready"}, bus.ready, 1'b0);
    tick();
    chk({tag, "_sram_rd"}, bus.sram_read_en, 1'b1);
    chk({tag, "_sram_addr"}, bus.sram_address, addr);
    bus.sram_ready     = 1'b1;
    bus.sram_read_data = line;
    #1;
    chk({tag, "_fill_ready"}, bus.ready, 1'b1);
    chk({tag, "_fill_data"}, bus.read_data, exp);
    tick();
    bus.sram_ready     = 1'b0;
    bus.sram_read_data = '0;
    set_req(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic write_txn(input string tag, input logic [31:0] addr, input logic [31:0] wdata);
    set_req(1'b0, 1'b1, addr, wdata);
    #1;
    chk({tag, "_idle_ready"}, bus.ready, 1'b0);
    chk({tag, "_idle_no_wr"}, bus.sram_write_en, 1'b0);
    tick();
    chk({tag, "_sram_wr"}, bus.sram_write_en, 1'b1);
    chk({tag, "_sram_addr"}, bus.sram_address, addr);
    chk({tag, "_sram_wdata"}, bus.sram_write_data, wdata);
    chk({tag, "_wait_ready"}, bus.ready, 1'b0);
    bus.sram_ready = 1'b1;
    #1;
    chk({tag, "_done_ready"}, bus.ready, 1'b1);
    tick();
    bus.sram_ready = 1'b0;
    set_req(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    rst                = 1'b1;
    bus.sram_ready     = 1'b0;
    bus.sram_read_data = '0;
    set_req(1'b0, 1'b0, 32'h0, 32'h0);

    // Reset behaviour
    tick();
    chk("rst_ready", bus.ready, 1'b1);
    chk("rst_sram_rd", bus.sram_read_en, 1'b0);
    chk("rst_sram_wr", bus.sram_write_en, 1'b0);
    chk("rst_rdata", bus.read_data, 32'h0);
    chk("rst_sram_addr", bus.sram_address, 32'h0);
    set_req(1'b1, 1'b0, 32'h400, 32'h0);
    #1;
    chk("rst_read_ready", bus.ready, 1'b0);
    chk("rst_read_sram_rd", bus.sram_read_en, 1'b0);
    set_req(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    rst = 1'b0;
    #1;

    // Miss fill then same-cycle hit on the other word of the line
    read_miss("fill400", 32'h400, 64'h22222222_11111111, 32'h11111111);
    read_hit("hit404", 32'h404, 32'h22222222);

    // Store hit: write-through plus cached word update
    write_txn("wr404", 32'h404, 32'hDEADBEEF);
    read_hit("hit404_new", 32'h404, 32'hDEADBEEF);

    // Read has priority over a simultaneous write; no store happens
    set_req(1'b1, 1'b1, 32'h404, 32'h12345678);
    #1;
    chk("rw_ready", bus.ready, 1'b1);
    chk("rw_rdata", bus.read_data, 32'hDEADBEEF);
    chk("rw_no_sram_wr", bus.sram_write_en, 1'b0);
    tick();
    set_req(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("rw_after_no_wr", bus.sram_write_en, 1'b0);
    read_hit("rw_unchanged", 32'h404, 32'hDEADBEEF);

    // Idle cycles; stray sram_ready pulses are ignored
    for (int i = 0; i < 10; i++) begin
      bus.sram_ready = i[0];
      #1;
      chk("idle_ready", bus.ready, 1'b1);
      chk("idle_sram_rd", bus.sram_read_en, 1'b0);
      chk("idle_sram_wr", bus.sram_write_en, 1'b0);
      tick();
    end
    bus.sram_ready = 1'b0;
    read_hit("idle_hit404", 32'h404, 32'hDEADBEEF);

    // Store miss: SRAM write only, no allocation
    write_txn("wrA00", 32'hA00, 32'hCAFEF00D);
    read_miss("missA00", 32'hA00, 64'h44444444_33333333, 32'h33333333);

    // LRU replacement within set 0
    do_reset();
    read_miss("lru_fill400", 32'h400, 64'hA1A1A1A1_A0A0A0A0, 32'hA0A0A0A0);
    read_miss("lru_fill600", 32'h600, 64'hB1B1B1B1_B0B0B0B0, 32'hB0B0B0B0);
    read_hit("lru_hit400", 32'h400, 32'hA0A0A0A0);
    read_hit("lru_hit604", 32'h604, 32'hB1B1B1B1);
    read_hit("lru_hit400b", 32'h400, 32'hA0A0A0A0);
    read_miss("lru_fill800", 32'h800, 64'hC1C1C1C1_C0C0C0C0, 32'hC0C0C0C0);
    read_hit("lru_keep400", 32'h404, 32'hA1A1A1A1);
    read_hit("lru_hit800", 32'h804, 32'hC1C1C1C1);
    read_hit("lru_keep400b", 32'h400, 32'hA0A0A0A0);
    read_miss("lru_evict600", 32'h600, 64'hB3B3B3B3_B2B2B2B2, 32'hB2B2B2B2);
    read_hit("lru_after400", 32'h400, 32'hA0A0A0A0);

    // Reset in the middle of a miss aborts it without allocating
    do_reset();
    set_req(1'b1, 1'b0, 32'h400, 32'h0);
    tick();
    chk("abort_sram_rd", bus.sram_read_en, 1'b1);
    rst                = 1'b1;
    bus.sram_ready     = 1'b1;
    bus.sram_read_data = 64'h66666666_55555555;
    #1;
    chk("abort_rd_drop", bus.sram_read_en, 1'b0);
    chk("abort_ready", bus.ready, 1'b0);
    chk("abort_rdata", bus.read_data, 32'h0);
    chk("abort_sram_addr", bus.sram_address, 32'h0);
    tick();
    tick();
    bus.sram_ready     = 1'b0;
    bus.sram_read_data = '0;
    rst                = 1'b0;
    #1;
    chk("abort_still_miss", bus.ready, 1'b0);
    tick();
    chk("abort_refetch", bus.sram_read_en, 1'b1);
    bus.sram_ready     = 1'b1;
    bus.sram_read_data = 64'h88888888_77777777;
    #1;
    chk("abort_fill_ready", bus.ready, 1'b1);
    chk("abort_fill_data", bus.read_data, 32'h77777777);
    tick();
    bus.sram_ready     = 1'b0;
    bus.sram_read_data = '0;
    set_req(1'b0, 1'b0, 32'h0, 32'h0);
    read_hit("abort_hit404", 32'h404, 32'h88888888);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
